uart_rx_frame_ctrl: RTL
=======================

# uart_rx_frame_ctrl

Receive-frame controller for the UART, clocked by the 2x-baud clock `clk_2br`. It sequences reception of one asynchronous frame: start detection with false-start rejection, LSB-first data capture, optional parity, and stop-bit check. Each completed byte is delivered through a one-deep holding register with a valid/ready handshake, together with per-byte error flags and a sticky overrun flag. It sits between the `rx` pin and the byte consumer (FIFO or host register interface).

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal values are 5 to 8.
- `clk_2br`  in  1  2x-baud clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `par_en`  in  1  1 = a parity bit follows the data bits.
- `par_odd`  in  1  1 = odd parity, 0 = even parity.
- `data_ready`  in  1  consumer accepts the held byte.
- `clr_ovr`  in  1  clears `overrun`.
- `data_out`  out  DATA_BITS  received byte, LSB = first data bit.
- `data_valid`  out  1  the holding register contains an unread byte.
- `par_err`  out  1  parity mismatch for the held byte.
- `frame_err`  out  1  stop bit was sampled as 0 for the held byte.
- `overrun`  out  1  sticky; set when a completed frame was dropped.
- `busy`  out  1  high in every state except IDLE.
- `sample`  out  1  one-cycle pulse on each bit-sample edge (start, data, parity, stop).

## Operation
- `rx` passes through a 2-flop synchronizer to produce `rx_s`. Both flops reset to 1.
- Bit timing: 2 ticks per bit. Start detection occurs at the first tick the line is low. All later samples occur at bit centres, every 2 ticks.
- States: IDLE, START, DATA, PARITY, STOP, BRK.
- IDLE: if `rx_s` = 0, go to START. `par_en` and `par_odd` are latched on this edge; changing them mid-frame has no effect on the current frame.
- START: sample `rx_s`.
  - If 1 (false start), return to IDLE with no output.
  - If 0, go to DATA with bit count = 0 and phase = 0.
- DATA: phase toggles every tick. On phase 1, shift `rx_s` in from the MSB side (LSB-first reception) and increment the bit count. After bit DATA_BITS-1, go to PARITY if `par_en`, else go to STOP.
- PARITY: sample on phase 1. Error = XOR(data bits, parity bit, `par_odd`) != 0. That is, even parity requires the total count of ones to be even; odd parity requires it to be odd.
- STOP: sample on phase 1.
  - If `rx_s` = 1, go to IDLE.
  - If `rx_s` = 0, set the frame error and go to BRK.
- BRK: wait until `rx_s` = 1, then go to IDLE. This prevents a low break line from retriggering a start.
- Frame completion happens on the stop-sample edge.
  - Holding register empty, or `data_ready` = 1 on this same edge: load `data_out`, `par_err` and `frame_err`, and set `data_valid`.
  - Holding register full and `data_ready` = 0: discard the new frame, keep the old byte and its flags, and set `overrun`.
- Handshake:
  - `data_valid` clears on an edge where `data_valid` and `data_ready` are both 1, unless a frame completes on that same edge.
  - `data_out` and the flags hold stable while `data_valid` = 1.
- `overrun` stays set until `clr_ovr` = 1. If set and clear occur on the same edge, set wins.
- `par_err` is 0 when `par_en` was latched as 0.

## Timing
- Reset values: state = IDLE, `data_out` = 0, `data_valid` = 0, `par_err` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0, `sample` = 0.
- Reset asserted mid-frame aborts the frame with no output and clears the holding register.
- Edge numbering: edge 0 is the IDLE edge that sees `rx_s` = 0. The `rx` line falls 2 edges earlier, because of the synchronizer.
- Sample edges:
  - start sample: edge 1
  - data bit k: edge 3+2k
  - parity: edge 3+2·DATA_BITS
  - stop: edge 3+2·(DATA_BITS+P), where P = 1 if parity is enabled, else 0
- 8N1: stop is sampled on edge 19, and `data_valid` is visible after edge 19. 8E1: edge 21.
- `busy` goes high after edge 0 and low after the stop edge (or after the BRK exit edge).
- `sample` goes high for one cycle following each sample edge.
- Back-to-back frames: a new start bit is detected on the edge after the return to IDLE. There are no idle gaps beyond the stop bit.

## Test plan
- 8N1, byte 0xA5, `data_ready` held low → `data_out` = 0xA5 and `data_valid` = 1 after edge 19; all error flags 0; exactly 10 `sample` pulses.
- 8E1, byte 0x03 with parity bit 1 → `data_out` = 0x03, `par_err` = 1. Same stimulus with `par_odd` = 1 → `par_err` = 0.
- Line low for 1 tick only (glitch) → START samples 1 and returns to IDLE; no `data_valid`; `busy` high for exactly 1 cycle.
- Byte 0x00 with stop bit 0, line then held low for 20 ticks → `frame_err` = 1, `data_out` = 0x00. FSM stays in BRK until the line goes high, and no second frame is produced.
- Two frames 0x11 then 0x22 with `data_ready` = 0 → `data_out` stays 0x11 and `overrun` = 1. Then `clr_ovr` → `overrun` = 0. Repeat with `data_ready` = 1 on the second stop edge → `data_out` = 0x22 and `overrun` stays 0.
- `reset` asserted at edge 9 of a frame → all outputs return to their reset values on the next edge; a clean frame 0x5A afterwards is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive-frame controller on the 2x-baud clock.
// Start/false-start, LSB-first data, optional parity, stop check, one-deep hold.
module uart_rx_frame_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_2br,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 par_en,
    input  logic                 par_odd,
    input  logic                 data_ready,
    input  logic                 clr_ovr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 sample
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_m;
    logic                 rx_s;
    logic                 phase;
    logic                 phase_nxt;
    logic [CW-1:0]        bit_cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 par_bad;
    logic                 par_bad_nxt;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 latch_cfg;
    logic                 smp;
    logic                 done;
    logic                 stop_bad;
    logic                 load;
    logic                 drop;

    always_ff @(posedge clk_2br) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk_2br) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bad   <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            sample    <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            bit_cnt   <= cnt_nxt;
            shift_reg <= shift_nxt;
            par_bad   <= par_bad_nxt;
            sample    <= smp;
            if (latch_cfg) begin
                par_en_q  <= par_en;
                par_odd_q <= par_odd;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        cnt_nxt     = bit_cnt;
        shift_nxt   = shift_reg;
        par_bad_nxt = par_bad;
        latch_cfg   = 1'b0;
        smp         = 1'b0;
        done        = 1'b0;
        stop_bad    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt   = START;
                    latch_cfg   = 1'b1;
                    par_bad_nxt = 1'b0;
                end
            end
            START: begin
                smp = 1'b1;
                if (rx_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DATA;
                    phase_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                phase_nxt = ~phase;
                if (phase) begin
                    smp       = 1'b1;
                    shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
                    cnt_nxt   = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                phase_nxt = ~phase;
                if (phase) begin
                    smp         = 1'b1;
                    par_bad_nxt = (^shift_reg) ^ rx_s ^ par_odd_q;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                phase_nxt = ~phase;
                if (phase) begin
                    smp       = 1'b1;
                    done      = 1'b1;
                    stop_bad  = ~rx_s;
                    state_nxt = rx_s ? IDLE : BRK;
                end
            end
            BRK: begin
                // hold off until the line recovers so a break is not a start
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign load = done && (!data_valid || data_ready);
    assign drop = done && data_valid && !data_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk_2br) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            frame_err  <= 1'b0;
        end else if (load) begin
            data_out   <= shift_reg;
            data_valid <= 1'b1;
            par_err    <= par_bad & par_en_q;
            frame_err  <= stop_bad;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_2br) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule
